mem_arbiter: RTL

- Sequences the single byte-wide RAM port. Shares it between two requesters:
  - the instruction-fetch stage: 4-byte reads, refilling its icache;
  - the load/store buffer: 1/2/4-byte reads and writes.
- Converts each granted request into consecutive byte accesses, assembles or splits little-endian words, and returns a one-cycle done pulse to the owner.
- Sits between the fetch/LSB stages and the top-level RAM/IO pins.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings, defaults and register layout for mem_arbiter
package mem_arbiter_pkg;
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   typedef struct packed {
      state_t      st;
      logic        ls;
      logic [31:0] base;
      logic [2:0]  n;
      logic [31:0] wd;
      logic [2:0]  k;
      logic [31:0] acc;
      logic [3:0]  cnt;
      logic [31:0] a;
      logic        wr;
      logic [7:0]  dout;
      logic        ifd;
      logic [31:0] inst;
      logic        lsd;
      logic [31:0] rdat;
   } regs_t;
   function automatic logic [2:0] size_bytes(input logic [1:0] s);
      return s == SIZE_B ? 3'd1 : s == SIZE_H ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and the load/store buffer.
// Define MEM_IO_STALL_EN to hold IO stores in IDLE while io_buffer_full is set.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear_in,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);
   regs_t r, nx;
   logic stall, if_ok, g_ls, g_if;
`ifdef MEM_IO_STALL_EN
   assign stall = ls_we && ls_addr >= IO_BASE && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = io_buffer_full & (ls_addr >= IO_BASE);
   assign stall = 1'b0;
`endif
   assign if_ok = if_req && !clear_in;
   assign g_ls = r.st == IDLE && ls_req && !stall && !(if_ok && int'(r.cnt) >= STARVE_LIMIT);
   assign g_if = r.st == IDLE && if_ok && !g_ls;
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) r <= '0;
      else if (rdy_in) r <= nx;
   always_comb begin
      nx = r;
      nx.ifd = 1'b0;
      nx.lsd = 1'b0;
      nx.wr = 1'b0;
      case (r.st)
         IDLE: begin
            nx.a = g_ls ? ls_addr : g_if ? if_addr : '0;
            nx.dout = (g_ls && ls_we) ? ls_wdata[7:0] : 8'd0;
            nx.wr = g_ls && ls_we;
            if (g_ls || g_if) begin
               nx.ls = g_ls;
               nx.base = nx.a;
               nx.n = g_ls ? size_bytes(ls_size) : 3'd4;
               nx.wd = ls_wdata;
               nx.k = 3'd1;
               nx.acc = '0;
               nx.st = (g_ls && ls_we) ? WRITE : READ;
            end
         end
         READ: begin
            nx.k = r.k + 3'd1;
            nx.a = (r.k < r.n) ? r.base + {29'd0, r.k} : '0;
            // mem_din lags mem_a by one cycle, so byte k-2 arrives in cycle k
            if (r.k >= 3'd2) nx.acc = r.acc | ({24'd0, mem_din} << (8 * (r.k - 3'd2)));
            if (clear_in && !r.ls) begin
               nx.st = IDLE;
               nx.a = '0;
            end else if (r.k == r.n + 3'd1) begin
               nx.st = DONE;
               nx.ifd = !r.ls;
               nx.lsd = r.ls;
               nx.inst = r.ls ? r.inst : nx.acc;
               nx.rdat = r.ls ? nx.acc : r.rdat;
            end
         end
         WRITE: begin
            nx.k = r.k + 3'd1;
            nx.wr = r.k < r.n;
            nx.a = (r.k < r.n) ? r.base + {29'd0, r.k} : '0;
            nx.dout = (r.k < r.n) ? 8'(r.wd >> (8 * r.k)) : 8'd0;
            nx.st = (r.k < r.n) ? WRITE : DONE;
            nx.lsd = !(r.k < r.n);
         end
         default: nx.st = IDLE;
      endcase
      nx.cnt = (!if_req || g_if) ? 4'd0 : (g_ls && r.cnt != 4'd15) ? r.cnt + 4'd1 : r.cnt;
   end
   assign mem_a = r.a;
   assign mem_wr = r.wr & rdy_in;
   assign mem_dout = r.dout;
   assign if_done = r.ifd & ~clear_in;
   assign if_inst = r.inst;
   assign ls_done = r.lsd;
   assign ls_rdata = r.rdat;
endmodule
